// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage on a req/gnt/rvalid bus.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_mem_read,
   input  logic            i_mem_write,
   input  logic [1:0]      i_d_size,
   input  logic            i_d_unsigned,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_busy,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_rvalid,
   output logic            o_misaligned,
   output logic            o_bus_err,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [3:0]      o_dmem_be,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_gnt,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] LP_LIM = 8'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   logic [1:0]      r_size;
   logic [1:0]      r_off;
   logic            r_uns;

   logic            w_access;
   logic            w_misal;
   logic            w_start;
   logic            w_tmo;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_shift;
   logic [XLEN-1:0] w_ext;

   assign w_access = i_mem_read | i_mem_write;
   assign w_start  = (r_state == S_IDLE) & w_access & ~w_misal;

   // Alignment check on the presented access
   always_comb begin
      w_misal = 1'b0;
      if (w_access) begin
         unique case (1'b1)
            (i_d_size == 2'b01): w_misal = i_addr[0];
            i_d_size[1]:         w_misal = (i_addr[1:0] != 2'b00);
            default:             w_misal = 1'b0;
         endcase
      end
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_wdata;
      unique case (i_d_size)
         2'b00: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << i_addr[1:0];
            w_wdata = {2{i_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_wdata;
         end
      endcase
   end

   // Align the returned word and sign/zero-extend it
   always_comb begin
      w_shift = i_dmem_rdata >> {r_off, 3'b000};
      w_ext   = w_shift;
      unique case (r_size)
         2'b00:   w_ext = {{24{~r_uns & w_shift[7]}},
                           w_shift[7:0]};
         2'b01:   w_ext = {{16{~r_uns & w_shift[15]}},
                           w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [7:0] r_cnt;

   // Cycle counter for the current REQ/WAIT phase
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 8'd0;
      end else if (w_start ||
                   (r_state == S_REQ && i_dmem_gnt)) begin
         r_cnt <= 8'd0;
      end else if (r_state == S_REQ ||
                   r_state == S_WAIT) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign w_tmo = (r_cnt == LP_LIM) &&
                  ((r_state == S_REQ  && !i_dmem_gnt) ||
                   (r_state == S_WAIT && !i_dmem_rvalid));
`else
   logic w_unused_lim;
   assign w_unused_lim = ^LP_LIM;
   assign w_tmo        = 1'b0;
`endif

   // Stall, misalignment and bus-error indications
   always_comb begin
      o_busy       = 1'b0;
      o_misaligned = 1'b0;
      o_bus_err    = 1'b0;
      if (!i_rst) begin
         unique case (r_state)
            S_IDLE: begin
               o_busy       = w_start;
               o_misaligned = (r_state == S_IDLE) & w_misal;
            end
            S_REQ: begin
               o_busy    = ~(w_tmo | (i_dmem_gnt & o_dmem_we));
               o_bus_err = w_tmo;
            end
            S_WAIT: begin
               o_busy    = ~w_tmo;
               o_bus_err = w_tmo;
            end
            default: o_busy = 1'b0;
         endcase
      end
   end

   // Access sequencing with registered bus and response outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_size       <= 2'b00;
         r_off        <= 2'b00;
         r_uns        <= 1'b0;
         o_rdata      <= '0;
         o_rvalid     <= 1'b0;
         o_dmem_req   <= 1'b0;
         o_dmem_we    <= 1'b0;
         o_dmem_addr  <= '0;
         o_dmem_be    <= 4'b0000;
         o_dmem_wdata <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               o_rvalid <= 1'b0;
               if (w_start) begin
                  r_size       <= i_d_size;
                  r_off        <= i_addr[1:0];
                  r_uns        <= i_d_unsigned;
                  o_dmem_req   <= 1'b1;
                  o_dmem_we    <= ~i_mem_read;
                  o_dmem_addr  <= {i_addr[XLEN-1:2], 2'b00};
                  o_dmem_be    <= w_be;
                  o_dmem_wdata <= w_wdata;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_dmem_gnt) begin
                  o_dmem_req <= 1'b0;
                  if (o_dmem_we) begin
                     r_state <= S_IDLE;
                  end else if (i_dmem_rvalid) begin
                     o_rdata  <= w_ext;
                     o_rvalid <= 1'b1;
                     r_state  <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end else if (w_tmo) begin
                  o_dmem_req <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (i_dmem_rvalid) begin
                  o_rdata  <= w_ext;
                  o_rvalid <= 1'b1;
                  r_state  <= S_RESP;
               end else if (w_tmo) begin
                  r_state <= S_IDLE;
               end
            end
            S_RESP: begin
               o_rvalid <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
